spi_display_cmd: RTL and testbench

Command decoder between the SPI slave byte interface and the 4-digit 7-segment display driver. Frames received SPI bytes into display commands, owns the digit/colon registers that feed the display driver, and returns one response byte per received byte on the SPI transmit interface. Replaces direct wiring of received bytes to digits.

---
 rtl/spi_display_cmd.sv | 141 ++++++++++++++
 tb/tb_spi_display_cmd.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spi_display_cmd.sv
// Command decoder between the SPI byte interface and the 4-digit display driver.
// Owns the digit/colon registers and returns one response byte per received byte.
module spi_display_cmd #(
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_ready,
    input  logic [7:0] rx,
    input  logic       spi_cs,
    output logic [7:0] tx,
    output logic       tx_ready,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic [7:0] err_count
);

    // state | meaning
    // IDLE  | waiting for a command byte
    // WR1   | waiting for single-digit data byte
    // PK1   | waiting for first packed byte (digit3, digit2)
    // PK2   | waiting for second packed byte (digit1, digit0)
    typedef enum logic [1:0] {IDLE, WR1, PK1, PK2} state_t;

    state_t          state, state_n;
    logic            cs_q1, cs_s, rx_ready_q, evt, reject;
    logic [1:0]      index, index_n;
    logic [7:0]      stage, stage_n;
    logic [3:0][3:0] digits, digits_n;
    logic [1:0]      colon_n;
    logic [7:0]      tx_n, err_n;
    logic            tx_ready_n;

    assign evt    = rx_ready & ~rx_ready_q;
    assign digit0 = digits[0];
    assign digit1 = digits[1];
    assign digit2 = digits[2];
    assign digit3 = digits[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q1      <= 1'b1;
            cs_s       <= 1'b1;
            rx_ready_q <= 1'b0;
            state      <= IDLE;
            index      <= 2'd0;
            stage      <= 8'h00;
            digits     <= '0;
            colon      <= 2'b11;
            tx         <= 8'h00;
            tx_ready   <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            cs_q1      <= spi_cs;
            cs_s       <= cs_q1;
            rx_ready_q <= rx_ready;
            state      <= state_n;
            index      <= index_n;
            stage      <= stage_n;
            digits     <= digits_n;
            colon      <= colon_n;
            tx         <= tx_n;
            tx_ready   <= tx_ready_n;
            err_count  <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        index_n    = index;
        stage_n    = stage;
        digits_n   = digits;
        colon_n    = colon;
        tx_n       = tx;
        tx_ready_n = 1'b0;
        err_n      = err_count;
        reject     = 1'b0;

        // Deselect discards any partial command; a coincident byte is dropped.
        if (cs_s) begin
            state_n = IDLE;
        end else if (evt) begin
            tx_ready_n = 1'b1;
            tx_n       = ACK_BYTE;
            case (state)
                IDLE: begin
                    case (rx[7:4])
                        4'h1: begin
                            if (rx[3:2] == 2'b00) begin
                                index_n = rx[1:0];
                                state_n = WR1;
                            end else begin
                                reject = 1'b1;
                            end
                        end
                        4'h2: begin
                            if (rx[3:2] == 2'b00) colon_n = rx[1:0];
                            else                  reject  = 1'b1;
                        end
                        4'h3: begin
                            if (rx[3:2] == 2'b00) tx_n   = {4'h0, digits[rx[1:0]]};
                            else                  reject = 1'b1;
                        end
                        4'h5: begin
                            if (rx[3:0] == 4'h0) state_n = PK1;
                            else                 reject  = 1'b1;
                        end
                        default: reject = 1'b1;
                    endcase
                end
                WR1: begin
                    if (rx[3:0] <= 4'd9) digits_n[index] = rx[3:0];
                    else                 reject          = 1'b1;
                    state_n = IDLE;
                end
                PK1: begin
                    stage_n = rx;
                    state_n = PK2;
                end
                PK2: begin
                    if (stage[7:4] <= 4'd9 && stage[3:0] <= 4'd9 &&
                        rx[7:4] <= 4'd9 && rx[3:0] <= 4'd9)
                        digits_n = {stage[7:4], stage[3:0], rx[7:4], rx[3:0]};
                    else
                        reject = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
            if (reject) begin
                tx_n  = ERR_BYTE;
                err_n = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_display_cmd.sv
// Directed bench for spi_display_cmd: a byte/response table plus hand-written
// sequences for saturation, deselect, reset and coincident-deselect cases.
module tb_spi_display_cmd;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_ready;
    logic [7:0] rx;
    logic       spi_cs;
    logic [7:0] tx;
    logic       tx_ready;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic [7:0] err_count;

    int vectors    = 0;
    int miscompares = 0;

    spi_display_cmd dut (
        .clk       (clk),
        .reset     (reset),
        .rx_ready  (rx_ready),
        .rx        (rx),
        .spi_cs    (spi_cs),
        .tx        (tx),
        .tx_ready  (tx_ready),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .colon     (colon),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rx;
        int          width;
        logic [7:0]  tx;
        logic [15:0] digs;
        logic [1:0]  colon;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one byte with an rx_ready strobe 'width' cycles long; returns
    // tx/tx_ready as seen one clk after the rising edge of the strobe.
    task automatic send(input logic [7:0] b, input int width,
                        output logic [7:0] got_tx, output logic got_ready);
        @(negedge clk);
        rx       = b;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        got_tx    = tx;
        got_ready = tx_ready;
        for (int i = 1; i < width; i++) begin
            @(posedge clk);
            #1;
            check("tx_ready_single_pulse", {31'd0, tx_ready}, 32'd0);
        end
        @(negedge clk);
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        check("tx_ready_low_after", {31'd0, tx_ready}, 32'd0);
    endtask

    function automatic logic [15:0] digs();
        return {digit3, digit2, digit1, digit0};
    endfunction

    logic [7:0] t;
    logic       r;

    initial begin
        vecs[0]  = '{8'h12, 5, 8'hA5, 16'h0000, 2'b11, 8'd0};
        vecs[1]  = '{8'h07, 1, 8'hA5, 16'h0700, 2'b11, 8'd0};
        vecs[2]  = '{8'h50, 1, 8'hA5, 16'h0700, 2'b11, 8'd0};
        vecs[3]  = '{8'h12, 1, 8'hA5, 16'h0700, 2'b11, 8'd0};
        vecs[4]  = '{8'h34, 2, 8'hA5, 16'h1234, 2'b11, 8'd0};
        vecs[5]  = '{8'h33, 1, 8'h01, 16'h1234, 2'b11, 8'd0};
        vecs[6]  = '{8'h30, 1, 8'h04, 16'h1234, 2'b11, 8'd0};
        vecs[7]  = '{8'h50, 1, 8'hA5, 16'h1234, 2'b11, 8'd0};
        vecs[8]  = '{8'h12, 1, 8'hA5, 16'h1234, 2'b11, 8'd0};
        vecs[9]  = '{8'h3A, 1, 8'hEE, 16'h1234, 2'b11, 8'd1};
        vecs[10] = '{8'h10, 1, 8'hA5, 16'h1234, 2'b11, 8'd1};
        vecs[11] = '{8'h0C, 1, 8'hEE, 16'h1234, 2'b11, 8'd2};
        vecs[12] = '{8'h21, 1, 8'hA5, 16'h1234, 2'b01, 8'd2};
        vecs[13] = '{8'h24, 1, 8'hEE, 16'h1234, 2'b01, 8'd3};
        vecs[14] = '{8'h60, 1, 8'hEE, 16'h1234, 2'b01, 8'd4};
        vecs[15] = '{8'h14, 1, 8'hEE, 16'h1234, 2'b01, 8'd5};
        vecs[16] = '{8'h13, 1, 8'hA5, 16'h1234, 2'b01, 8'd5};
        vecs[17] = '{8'h09, 3, 8'hA5, 16'h9234, 2'b01, 8'd5};
        vecs[18] = '{8'h32, 1, 8'h02, 16'h9234, 2'b01, 8'd5};

        reset    = 1'b1;
        rx_ready = 1'b0;
        rx       = 8'h00;
        spi_cs   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits",   {16'd0, digs()},      32'h0000);
        check("reset_colon",    {30'd0, colon},       32'h3);
        check("reset_tx",       {24'd0, tx},          32'h00);
        check("reset_tx_ready", {31'd0, tx_ready},    32'd0);
        check("reset_err",      {24'd0, err_count},   32'd0);

        @(negedge clk);
        reset  = 1'b0;
        spi_cs = 1'b0;
        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].rx, vecs[i].width, t, r);
            check($sformatf("v%0d_tx_ready", i), {31'd0, r},         32'd1);
            check($sformatf("v%0d_tx", i),       {24'd0, t},         {24'd0, vecs[i].tx});
            check($sformatf("v%0d_digits", i),   {16'd0, digs()},    {16'd0, vecs[i].digs});
            check($sformatf("v%0d_colon", i),    {30'd0, colon},     {30'd0, vecs[i].colon});
            check($sformatf("v%0d_err", i),      {24'd0, err_count}, {24'd0, vecs[i].err});
        end

        // err_count saturation
        for (int i = 0; i < 300; i++) send(8'hFF, 1, t, r);
        check("sat_tx",  {24'd0, t},         32'hEE);
        check("sat_err", {24'd0, err_count}, 32'hFF);

        // Deselect discards a pending single-digit write
        send(8'h11, 1, t, r);
        check("cs_cmd_tx", {24'd0, t}, 32'hA5);
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (3) @(posedge clk);
        send(8'h05, 1, t, r);
        check("cs_reselect_tx", {24'd0, t},         32'hEE);
        check("cs_digit1",      {28'd0, digit1},    32'h3);
        check("cs_err_sat",     {24'd0, err_count}, 32'hFF);

        // Reset in the middle of a packed command
        send(8'h50, 1, t, r);
        check("pk_start_tx", {24'd0, t}, 32'hA5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_digits",   {16'd0, digs()},    32'h0000);
        check("mid_reset_colon",    {30'd0, colon},     32'h3);
        check("mid_reset_tx",       {24'd0, tx},        32'h00);
        check("mid_reset_tx_ready", {31'd0, tx_ready},  32'd0);
        check("mid_reset_err",      {24'd0, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        send(8'h37, 1, t, r);
        check("post_reset_ready", {31'd0, r},         32'd1);
        check("post_reset_tx",    {24'd0, t},         32'hEE);
        check("post_reset_err",   {24'd0, err_count}, 32'd1);

        // Byte arriving while deselected is dropped
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (3) @(posedge clk);
        send(8'h30, 1, t, r);
        check("desel_no_ready", {31'd0, r},         32'd0);
        check("desel_tx_hold",  {24'd0, tx},        32'hEE);
        check("desel_err",      {24'd0, err_count}, 32'd1);
        send(8'h13, 1, t, r);
        check("desel_no_ready2", {31'd0, r},      32'd0);
        check("desel_digits",    {16'd0, digs()}, 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
